// File: rtl/arm_mul_pkg.sv
// Shared constants and state encoding for the ARM MUL/MLA shift-add multiplier.
package arm_mul_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEL_W_DEF = 4;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/arm_mul_step.sv
// One combinational shift-add iteration of the multiplier.
// ARM_MUL_EARLY_TERM_EN: also flag the last iteration once the shifted multiplier is zero.
module arm_mul_step
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o,
  output logic             last_o
);

  always_comb begin
    if (mplier_i[0]) begin
      acc_o = acc_i + mcand_i;
    end else begin
      acc_o = acc_i;
    end
    mcand_o  = {mcand_i[WIDTH-2:0], 1'b0};
    mplier_o = {1'b0, mplier_i[WIDTH-1:1]};
    last_o   = (cnt_i == CNT_W'(MUL_ITERS - 1));
`ifdef ARM_MUL_EARLY_TERM_EN
    last_o   = last_o | (mplier_o == '0);
`endif
  end

endmodule

// File: rtl/arm_mul_unit.sv
// Multi-cycle MUL/MLA unit: latches operands on START, iterates, then issues one write-back.
// ARM_MUL_EARLY_TERM_EN (optional): stop as soon as no multiplier bits remain.
module arm_mul_unit
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             MLA,
  input  logic             S,
  input  logic [SEL_W-1:0] RD_IN,
  output logic [WIDTH-1:0] RESULT,
  output logic             N,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE,
  output logic [SEL_W-1:0] WB_SEL,
  output logic             WB_EN
);

  mul_state_e       state_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_q;
  logic [SEL_W-1:0] rd_q;

  logic [WIDTH-1:0] acc_d, mcand_d, mplier_d;
  logic             last_s;

  arm_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .cnt_i    (cnt_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d),
    .last_o   (last_s)
  );

  // FSM, datapath registers and registered outputs; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      s_q      <= 1'b0;
      rd_q     <= '0;
      RESULT   <= '0;
      N        <= 1'b0;
      Z        <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      WB_SEL   <= '0;
      WB_EN    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          DONE  <= 1'b0;
          WB_EN <= 1'b0;
          if (START) begin
            mcand_q  <= A;
            mplier_q <= B;
            acc_q    <= MLA ? C : '0;
            s_q      <= S;
            rd_q     <= RD_IN;
            cnt_q    <= '0;
            BUSY     <= 1'b1;
            state_q  <= MUL;
          end else begin
            BUSY     <= 1'b0;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_s) begin
            // Results are published straight from the final step so DONE lines up with FIN.
            RESULT  <= acc_d;
            WB_SEL  <= rd_q;
            DONE    <= 1'b1;
            WB_EN   <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= FIN;
            if (s_q) begin
              N <= acc_d[WIDTH-1];
              Z <= (acc_d == '0);
            end else begin
              N <= N;
              Z <= Z;
            end
          end else begin
            BUSY    <= 1'b1;
          end
        end
        FIN: begin
          DONE    <= 1'b0;
          WB_EN   <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          DONE    <= 1'b0;
          WB_EN   <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mul_unit.sv
// Self-checking bench for arm_mul_unit: directed cases from the test plan plus random MUL/MLA ops.
module tb_arm_mul_unit;

`ifdef ARM_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START, MLA, S;
  logic [31:0] A, B, C;
  logic [3:0]  RD_IN;
  logic [31:0] RESULT;
  logic        N, Z, BUSY, DONE, WB_EN;
  logic [3:0]  WB_SEL;

  int   checks = 0;
  int   errors = 0;
  logic n_m = 1'b0;
  logic z_m = 1'b0;

  arm_mul_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .A(A), .B(B), .C(C),
    .MLA(MLA), .S(S), .RD_IN(RD_IN), .RESULT(RESULT), .N(N), .Z(Z),
    .BUSY(BUSY), .DONE(DONE), .WB_SEL(WB_SEL), .WB_EN(WB_EN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_iters(input logic [31:0] b);
    int hi;
    hi = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i + 1;
    if (!EARLY) return 32;
    return (hi == 0) ? 1 : hi;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic mla, input logic s,
                        input logic [3:0] rd);
    logic [31:0] exp_r;
    int it, k, busy_cnt;
    bit seen;
    exp_r = a * b + (mla ? c : 32'd0);
    if (s) begin
      n_m = exp_r[31];
      z_m = (exp_r == 32'd0);
    end
    it = exp_iters(b);
    A = a; B = b; C = c; MLA = mla; S = s; RD_IN = rd; START = 1'b1;
    tick();
    START = 1'b0;
    A = $urandom; B = $urandom; C = $urandom; MLA = 1'($urandom); S = 1'($urandom); RD_IN = 4'($urandom);
    busy_cnt = BUSY ? 1 : 0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (DONE) seen = 1'b1;
      else if (BUSY) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(k), 32'(it));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(it));
    check({tag, "_done"}, {31'd0, DONE}, 32'd1);
    check({tag, "_wb_en"}, {31'd0, WB_EN}, 32'd1);
    check({tag, "_busy_fin"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_result"}, RESULT, exp_r);
    check({tag, "_wb_sel"}, {28'd0, WB_SEL}, {28'd0, rd});
    check({tag, "_nz"}, {30'd0, N, Z}, {30'd0, n_m, z_m});
    tick();
    check({tag, "_post_done"}, {30'd0, DONE, WB_EN}, 32'd0);
    check({tag, "_post_hold"}, RESULT, exp_r);
  endtask

  initial begin : stim
    logic [31:0] ra, rb, rc;
    logic [31:0] abort_b;
    bit saw_done;

    RESET = 1'b1; START = 1'b1; A = $urandom; B = $urandom; C = $urandom;
    MLA = 1'b0; S = 1'b1; RD_IN = 4'd5;
    tick();
    tick();
    check("reset_result", RESULT, 32'd0);
    check("reset_flags", {26'd0, N, Z, BUSY, DONE, WB_EN, 1'b0}, 32'd0);
    check("reset_wb_sel", {28'd0, WB_SEL}, 32'd0);
    RESET = 1'b0; START = 1'b0;
    tick();
    check("reset_start_dropped", {31'd0, BUSY}, 32'd0);

    run_op("mul", 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 4'd2);
    run_op("mla", 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 4'd7);
    run_op("wrap", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd3);
    run_op("noflag", 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'd9);
    run_op("early", 32'd4, 32'd1, 32'd0, 1'b0, 1'b1, 4'd1);
    run_op("bzero", 32'h1234_5678, 32'd0, 32'd6, 1'b1, 1'b1, 4'd15);

    // Abort: second START mid-iteration is ignored, then RESET kills the operation.
    abort_b = EARLY ? 32'h8000_0009 : 32'd9;
    A = 32'd7; B = abort_b; C = 32'd0; MLA = 1'b0; S = 1'b1; RD_IN = 4'd4; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("abort_busy_mid", {31'd0, BUSY}, 32'd1);
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_m = 1'b0;
    z_m = 1'b0;
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_result", RESULT, 32'd0);
    check("abort_outs", {27'd0, N, Z, DONE, WB_EN, 1'b0}, 32'd0);
    check("abort_wb_sel", {28'd0, WB_SEL}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (DONE || WB_EN || BUSY) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rc = $urandom;
      run_op("rand", ra, rb, rc, 1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
